time_set_ctrl: RTL and testbench
================================

# time_set_ctrl

Front-panel setting controller for the clock datapath. Turns three raw pushbuttons (mode, up, down) into the `ctrl_set`/`inc`/`dec` command interface that the hour, minute and second counters accept. It synchronises and debounces each button and sequences a RUN → SET_HOUR → SET_MIN → SET_SEC → RUN mode FSM. It issues single-cycle `inc`/`dec` pulses with hold-to-repeat, and produces a blink indicator for the field being edited.

## Interface
- DEBOUNCE_CYCLES, 16'd50000 — consecutive stable synchronised samples required to accept a level change (≥2)
- REPEAT_DELAY, 24'd5000000 — cycles from first pulse of a held up/down to first repeat pulse (≥2)
- REPEAT_PERIOD, 24'd1000000 — cycles between subsequent repeat pulses (≥2)
- TIMEOUT_CYCLES, 32'd500000000 — idle cycles in any SET state before automatic return to RUN (≥2)
- BLINK_HALF, 24'd12500000 — cycles per blink half-period (≥1)
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- btn_mode  in  1  raw mode pushbutton, active-high, asynchronous
- btn_up  in  1  raw up pushbutton, active-high, asynchronous
- btn_down  in  1  raw down pushbutton, active-high, asynchronous
- ctrl_set_hour  out  1  hour counter in set mode
- ctrl_set_min  out  1  minute counter in set mode
- ctrl_set_sec  out  1  second counter in set mode
- inc  out  1  one-cycle increment command, shared by all counters
- dec  out  1  one-cycle decrement command, shared by all counters
- blink  out  1  display blank toggle for the selected field

## Operation
- Reset: FSM = RUN; all outputs 0; debounced levels 0; all counters 0.
- Per button: 2-FF synchroniser, then debounce counter. The counter clears whenever the synchronised value equals the debounced level, otherwise increments. When it reaches DEBOUNCE_CYCLES−1 it loads the new level and clears. A press is the rising edge of the debounced level.
- FSM states: RUN, SET_HOUR, SET_MIN, SET_SEC.
  - Mode press advances RUN→SET_HOUR→SET_MIN→SET_SEC→RUN.
  - Timeout from any SET state → RUN.
- ctrl_set_* is a registered one-hot decode of the state; all are 0 in RUN.
- Up/down handling (SET states only; ignored in RUN):
  - A press of up alone → `inc` for 1 cycle; a press of down alone → `dec` for 1 cycle.
  - While the same single button stays held, the repeat counter produces its first repeat pulse REPEAT_DELAY cycles after the initial pulse, then one pulse every REPEAT_PERIOD cycles.
- Boundary cases:
  - Both up and down debounced high: no pulses, repeat counter cleared. A release of one of them does not restart a press; a new press edge is required.
  - Mode press in the same cycle as an up/down press: mode wins and the up/down press is dropped. Any state change clears the repeat counter, so a button held across a mode change issues nothing until it is re-pressed.
  - `inc` and `dec` are never high in the same cycle.
- Timeout counter:
  - Clears on any press edge (mode, up or down) and on every state change.
  - Counts only in SET states.
  - On reaching TIMEOUT_CYCLES−1 → RUN.
- Blink: a toggle flop driven by a BLINK_HALF counter while in a SET state. It is forced to 0 in RUN, and both flop and counter restart at 0 on every state change.
- Wrap-around of field values is owned by the counters; this block never inspects counts.
- Reset asserted mid-hold or mid-repeat: immediate return to reset values. A button still held after reset deasserts is treated as a fresh press once debounced. Any resulting inc/dec is still dropped, because the FSM is in RUN.

## Timing
- Raw press sampled high at edge 0 and held → debounced level high after edge DEBOUNCE_CYCLES+2 → `inc`/`dec`/state change registered at edge DEBOUNCE_CYCLES+3.
- Release latency is identical; a release produces no output pulse.
- Glitches shorter than DEBOUNCE_CYCLES cycles produce no output.
- Repeat pulses are at initial+REPEAT_DELAY, then +REPEAT_PERIOD each. The pulse train stops the cycle after the debounced release.
- All outputs are registered; no combinational path from inputs to outputs.

## Structure
- Shared package `clock_pkg`:
  - mode state enum (RUN=0, SET_HOUR=1, SET_MIN=2, SET_SEC=3)
  - default parameter constants
- Sub-module `btn_debounce` (synchroniser + debounce + rise-edge output), instantiated three times.
- FSM, repeat, timeout and blink logic live in the top module.

## Test plan
Parameters: DEBOUNCE_CYCLES=4, REPEAT_DELAY=20, REPEAT_PERIOD=5, TIMEOUT_CYCLES=200, BLINK_HALF=10.
- Reset, then hold btn_up 50 cycles in RUN → inc never asserts; all ctrl_set_* = 0; blink = 0.
- Mode press → ctrl_set_hour=1 at edge 7 after the press. Three further presses walk SET_MIN, SET_SEC, RUN with one-hot ctrl_set_*.
- In SET_MIN, hold btn_up 60 cycles → inc pulses at edges 7, 27, 32, 37, … and none after release+6.
- Bounce btn_down high/low every 2 cycles for 30 cycles, then hold → exactly one dec pulse, 7 cycles after the stable hold begins.
- Hold btn_up, then press btn_down; release btn_down → no inc or dec while both are held, and no pulse after the btn_down release.
- Enter SET_SEC and stay idle 200 cycles → return to RUN with ctrl_set_sec=0 and blink=0. Assert rst during a repeat train → all outputs 0 immediately.

Source files
------------

// File: rtl/clock_pkg.sv
// Shared types and default timing constants for the clock datapath.
package clock_pkg;

   typedef enum logic [1:0] {
      RUN      = 2'd0,
      SET_HOUR = 2'd1,
      SET_MIN  = 2'd2,
      SET_SEC  = 2'd3
   } mode_e;

   localparam logic [15:0] DEF_DEBOUNCE_CYCLES = 16'd50000;
   localparam logic [23:0] DEF_REPEAT_DELAY    = 24'd5000000;
   localparam logic [23:0] DEF_REPEAT_PERIOD   = 24'd1000000;
   localparam logic [31:0] DEF_TIMEOUT_CYCLES  = 32'd500000000;
   localparam logic [23:0] DEF_BLINK_HALF      = 24'd12500000;

   function automatic mode_e next_mode(input mode_e m);
      case (m)
         RUN:      return SET_HOUR;
         SET_HOUR: return SET_MIN;
         SET_MIN:  return SET_SEC;
         default:  return RUN;
      endcase
   endfunction

endpackage

// File: rtl/btn_debounce.sv
// Two-flop synchroniser, stability-count debounce and rising-edge pulse
// for one raw pushbutton.
module btn_debounce
   import clock_pkg::*;
#(
   parameter logic [15:0] CYCLES = DEF_DEBOUNCE_CYCLES
) (
   input  logic clk,
   input  logic rst,
   input  logic btn_raw,
   output logic level,
   output logic rise
);

   logic        sync1_q, sync2_q;
   logic [15:0] cnt_q, cnt_d;
   logic        lvl_q, lvl_d;
   logic        out_q, out_d;
   logic        rise_q, rise_d;

   always_comb begin
      cnt_d = cnt_q;
      lvl_d = lvl_q;
      if (sync2_q == lvl_q) begin
         cnt_d = '0;
      end else if (cnt_q == CYCLES - 16'd1) begin
         lvl_d = sync2_q;
         cnt_d = '0;
      end else begin
         cnt_d = cnt_q + 16'd1;
      end
      out_d  = lvl_q;
      rise_d = lvl_q & ~out_q;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync1_q <= 1'b0;
         sync2_q <= 1'b0;
         cnt_q   <= '0;
         lvl_q   <= 1'b0;
         out_q   <= 1'b0;
         rise_q  <= 1'b0;
      end else begin
         sync1_q <= btn_raw;
         sync2_q <= sync1_q;
         cnt_q   <= cnt_d;
         lvl_q   <= lvl_d;
         out_q   <= out_d;
         rise_q  <= rise_d;
      end
   end

   assign level = out_q;
   assign rise  = rise_q;

endmodule

// File: rtl/time_set_ctrl.sv
// Front-panel setting controller: mode FSM, inc/dec with hold-to-repeat,
// idle timeout and blink for the field being edited.
module time_set_ctrl
   import clock_pkg::*;
#(
   parameter logic [15:0] DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
   parameter logic [23:0] REPEAT_DELAY    = DEF_REPEAT_DELAY,
   parameter logic [23:0] REPEAT_PERIOD   = DEF_REPEAT_PERIOD,
   parameter logic [31:0] TIMEOUT_CYCLES  = DEF_TIMEOUT_CYCLES,
   parameter logic [23:0] BLINK_HALF      = DEF_BLINK_HALF
) (
   input  logic clk,
   input  logic rst,
   input  logic btn_mode,
   input  logic btn_up,
   input  logic btn_down,
   output logic ctrl_set_hour,
   output logic ctrl_set_min,
   output logic ctrl_set_sec,
   output logic inc,
   output logic dec,
   output logic blink
);

   logic mode_lvl_unused, mode_p;
   logic up_l, up_p, dn_l, dn_p;

   btn_debounce #(.CYCLES(DEBOUNCE_CYCLES)) u_mode (
      .clk(clk), .rst(rst), .btn_raw(btn_mode),
      .level(mode_lvl_unused), .rise(mode_p)
   );
   btn_debounce #(.CYCLES(DEBOUNCE_CYCLES)) u_up (
      .clk(clk), .rst(rst), .btn_raw(btn_up),
      .level(up_l), .rise(up_p)
   );
   btn_debounce #(.CYCLES(DEBOUNCE_CYCLES)) u_down (
      .clk(clk), .rst(rst), .btn_raw(btn_down),
      .level(dn_l), .rise(dn_p)
   );

   mode_e       state_q, state_d;
   logic [23:0] rpt_cnt_q, rpt_cnt_d;
   logic        rpt_act_q, rpt_act_d;
   logic        rpt_first_q, rpt_first_d;
   logic [31:0] to_cnt_q, to_cnt_d;
   logic [23:0] blk_cnt_q, blk_cnt_d;
   logic        blink_q, blink_d;
   logic        hour_q, hour_d, min_q, min_d, sec_q, sec_d;
   logic        inc_q, inc_d, dec_q, dec_d;

   logic        in_set, chg, live, rpt_hit, fire;
   logic        single_up, single_dn;
   logic [23:0] rpt_lim;

   always_comb begin
      in_set = (state_q != RUN);
      state_d = state_q;
      if (mode_p)
         state_d = next_mode(state_q);
      else if (in_set && to_cnt_q == TIMEOUT_CYCLES - 32'd1)
         state_d = RUN;
      chg = (state_d != state_q);

      // Mode wins over a coincident up/down press; two held buttons cancel.
      single_up = up_l & ~dn_l;
      single_dn = dn_l & ~up_l;
      live      = in_set & ~chg & (single_up | single_dn);
      rpt_lim   = rpt_first_q ? REPEAT_DELAY : REPEAT_PERIOD;
      rpt_hit   = rpt_act_q & (rpt_cnt_q == rpt_lim - 24'd1);
      fire      = live & (up_p | dn_p | rpt_hit);
      inc_d     = fire & single_up;
      dec_d     = fire & single_dn;

      rpt_cnt_d   = rpt_cnt_q;
      rpt_act_d   = rpt_act_q;
      rpt_first_d = rpt_first_q;
      if (!live) begin
         rpt_cnt_d   = '0;
         rpt_act_d   = 1'b0;
         rpt_first_d = 1'b1;
      end else if (up_p | dn_p) begin
         rpt_cnt_d   = '0;
         rpt_act_d   = 1'b1;
         rpt_first_d = 1'b1;
      end else if (rpt_hit) begin
         rpt_cnt_d   = '0;
         rpt_first_d = 1'b0;
      end else if (rpt_act_q) begin
         rpt_cnt_d = rpt_cnt_q + 24'd1;
      end

      if (chg | mode_p | up_p | dn_p | ~in_set)
         to_cnt_d = '0;
      else
         to_cnt_d = to_cnt_q + 32'd1;

      blk_cnt_d = blk_cnt_q + 24'd1;
      blink_d   = blink_q;
      if (chg | ~in_set) begin
         blk_cnt_d = '0;
         blink_d   = 1'b0;
      end else if (blk_cnt_q == BLINK_HALF - 24'd1) begin
         blk_cnt_d = '0;
         blink_d   = ~blink_q;
      end

      hour_d = (state_d == SET_HOUR);
      min_d  = (state_d == SET_MIN);
      sec_d  = (state_d == SET_SEC);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= RUN;
         rpt_cnt_q   <= '0;
         rpt_act_q   <= 1'b0;
         rpt_first_q <= 1'b1;
         to_cnt_q    <= '0;
         blk_cnt_q   <= '0;
         blink_q     <= 1'b0;
         hour_q      <= 1'b0;
         min_q       <= 1'b0;
         sec_q       <= 1'b0;
         inc_q       <= 1'b0;
         dec_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         rpt_cnt_q   <= rpt_cnt_d;
         rpt_act_q   <= rpt_act_d;
         rpt_first_q <= rpt_first_d;
         to_cnt_q    <= to_cnt_d;
         blk_cnt_q   <= blk_cnt_d;
         blink_q     <= blink_d;
         hour_q      <= hour_d;
         min_q       <= min_d;
         sec_q       <= sec_d;
         inc_q       <= inc_d;
         dec_q       <= dec_d;
      end
   end

   assign ctrl_set_hour = hour_q;
   assign ctrl_set_min  = min_q;
   assign ctrl_set_sec  = sec_q;
   assign inc           = inc_q;
   assign dec           = dec_q;
   assign blink         = blink_q;

endmodule

// File: tb/tb_time_set_ctrl.sv
// Directed bench for time_set_ctrl with short timing parameters.
module tb_time_set_ctrl;

   logic clk, rst, btn_mode, btn_up, btn_down;
   logic ctrl_set_hour, ctrl_set_min, ctrl_set_sec;
   logic inc, dec, blink;
   logic [2:0] ctrl;

   int checks = 0;
   int errors = 0;

   assign ctrl = {ctrl_set_hour, ctrl_set_min, ctrl_set_sec};

   time_set_ctrl #(
      .DEBOUNCE_CYCLES(16'd4),
      .REPEAT_DELAY(24'd20),
      .REPEAT_PERIOD(24'd5),
      .TIMEOUT_CYCLES(32'd200),
      .BLINK_HALF(24'd10)
   ) dut (
      .clk(clk), .rst(rst),
      .btn_mode(btn_mode), .btn_up(btn_up), .btn_down(btn_down),
      .ctrl_set_hour(ctrl_set_hour), .ctrl_set_min(ctrl_set_min),
      .ctrl_set_sec(ctrl_set_sec),
      .inc(inc), .dec(dec), .blink(blink)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog simulation did not finish");
      $fatal(1);
   end

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic press_mode;
      btn_mode = 1'b1;
      repeat (8) tick();
      btn_mode = 1'b0;
      repeat (10) tick();
   endtask

   task automatic test_reset;
      rst = 1'b1;
      btn_mode = 1'b0;
      btn_up = 1'b0;
      btn_down = 1'b0;
      repeat (2) tick();
      checks++;
      if (ctrl !== 3'b000) begin
         errors++;
         $display("FAIL reset_ctrl got %b want 000", ctrl);
      end
      checks++;
      if ({inc, dec, blink} !== 3'b000) begin
         errors++;
         $display("FAIL reset_pulses got %b want 000", {inc, dec, blink});
      end
      rst = 1'b0;
      repeat (5) tick();
      checks++;
      if ({ctrl, inc, dec, blink} !== 6'b0) begin
         errors++;
         $display("FAIL post_reset got %b want 000000",
                  {ctrl, inc, dec, blink});
      end
   endtask

   task automatic test_run_ignores_up;
      int n_inc = 0;
      int n_other = 0;
      btn_up = 1'b1;
      for (int e = 0; e < 60; e++) begin
         if (e == 50) btn_up = 1'b0;
         tick();
         if (inc === 1'b1) n_inc++;
         if (ctrl !== 3'b000 || blink !== 1'b0 || dec !== 1'b0) n_other++;
      end
      checks++;
      if (n_inc != 0) begin
         errors++;
         $display("FAIL run_up_inc got %0d pulses want 0", n_inc);
      end
      checks++;
      if (n_other != 0) begin
         errors++;
         $display("FAIL run_up_outputs got %0d bad cycles want 0", n_other);
      end
   endtask

   task automatic test_mode_walk;
      logic [2:0] want [4] = '{3'b100, 3'b010, 3'b001, 3'b000};
      logic [2:0] prev;
      prev = 3'b000;
      for (int i = 0; i < 4; i++) begin
         btn_mode = 1'b1;
         tick();
         repeat (6) tick();
         checks++;
         if (ctrl !== prev) begin
            errors++;
            $display("FAIL walk%0d_edge6 got %b want %b", i, ctrl, prev);
         end
         tick();
         checks++;
         if (ctrl !== want[i]) begin
            errors++;
            $display("FAIL walk%0d_edge7 got %b want %b", i, ctrl, want[i]);
         end
         if (i == 0) begin
            repeat (9) tick();
            checks++;
            if (blink !== 1'b0) begin
               errors++;
               $display("FAIL blink_e16 got %b want 0", blink);
            end
            tick();
            checks++;
            if (blink !== 1'b1) begin
               errors++;
               $display("FAIL blink_e17 got %b want 1", blink);
            end
            repeat (10) tick();
            checks++;
            if (blink !== 1'b0) begin
               errors++;
               $display("FAIL blink_e27 got %b want 0", blink);
            end
         end
         btn_mode = 1'b0;
         repeat (10) tick();
         prev = want[i];
      end
   endtask

   task automatic test_repeat;
      int n = 0;
      int bad = 0;
      int first_bad = -1;
      logic exp;
      btn_up = 1'b1;
      tick();
      for (int e = 1; e <= 90; e++) begin
         if (e == 60) btn_up = 1'b0;
         tick();
         exp = (e == 7) || (e >= 27 && e <= 62 && (e - 27) % 5 == 0);
         if (inc === 1'b1) n++;
         if (inc !== exp || dec !== 1'b0) begin
            bad++;
            if (first_bad < 0) first_bad = e;
         end
      end
      checks++;
      if (bad != 0) begin
         errors++;
         $display("FAIL repeat_train got %0d bad edges (first %0d) want 0",
                  bad, first_bad);
      end
      checks++;
      if (n != 9) begin
         errors++;
         $display("FAIL repeat_count got %0d want 9", n);
      end
   endtask

   task automatic test_bounce_down;
      int glitch = 0;
      int n = 0;
      int bad = 0;
      for (int i = 0; i < 8; i++) begin
         btn_down = 1'b1;
         repeat (2) begin
            tick();
            if (inc === 1'b1 || dec === 1'b1) glitch++;
         end
         btn_down = 1'b0;
         repeat (2) begin
            tick();
            if (inc === 1'b1 || dec === 1'b1) glitch++;
         end
      end
      btn_down = 1'b1;
      tick();
      for (int e = 1; e <= 30; e++) begin
         if (e == 15) btn_down = 1'b0;
         tick();
         if (dec === 1'b1) n++;
         if (dec !== (e == 7) || inc !== 1'b0) bad++;
      end
      checks++;
      if (glitch != 0) begin
         errors++;
         $display("FAIL bounce_glitch got %0d pulses want 0", glitch);
      end
      checks++;
      if (bad != 0) begin
         errors++;
         $display("FAIL bounce_timing got %0d bad edges want 0", bad);
      end
      checks++;
      if (n != 1) begin
         errors++;
         $display("FAIL bounce_count got %0d want 1", n);
      end
   endtask

   task automatic test_both_held;
      int n_inc = 0;
      int n_dec = 0;
      int bad = 0;
      btn_up = 1'b1;
      tick();
      for (int e = 1; e <= 80; e++) begin
         if (e == 11) btn_down = 1'b1;
         if (e == 40) btn_down = 1'b0;
         if (e == 70) btn_up = 1'b0;
         tick();
         if (inc === 1'b1) n_inc++;
         if (dec === 1'b1) n_dec++;
         if (inc !== (e == 7)) bad++;
      end
      checks++;
      if (bad != 0) begin
         errors++;
         $display("FAIL both_timing got %0d bad edges want 0", bad);
      end
      checks++;
      if (n_inc != 1) begin
         errors++;
         $display("FAIL both_inc got %0d want 1", n_inc);
      end
      checks++;
      if (n_dec != 0) begin
         errors++;
         $display("FAIL both_dec got %0d want 0", n_dec);
      end
   endtask

   task automatic test_timeout;
      btn_mode = 1'b1;
      tick();
      for (int e = 1; e <= 210; e++) begin
         if (e == 8) btn_mode = 1'b0;
         tick();
         if (e == 7) begin
            checks++;
            if (ctrl !== 3'b001) begin
               errors++;
               $display("FAIL to_enter_sec got %b want 001", ctrl);
            end
         end
         if (e == 206) begin
            checks++;
            if (ctrl !== 3'b001 || blink !== 1'b1) begin
               errors++;
               $display("FAIL to_e206 got ctrl %b blink %b want 001 1",
                        ctrl, blink);
            end
         end
         if (e == 207) begin
            checks++;
            if (ctrl !== 3'b000 || blink !== 1'b0) begin
               errors++;
               $display("FAIL to_e207 got ctrl %b blink %b want 000 0",
                        ctrl, blink);
            end
         end
      end
      checks++;
      if (ctrl !== 3'b000) begin
         errors++;
         $display("FAIL to_stay_run got %b want 000", ctrl);
      end
   endtask

   task automatic test_mode_and_up;
      int n = 0;
      press_mode();
      btn_mode = 1'b1;
      btn_up = 1'b1;
      tick();
      for (int e = 1; e <= 40; e++) begin
         tick();
         if (inc === 1'b1 || dec === 1'b1) n++;
         if (e == 7) begin
            checks++;
            if (ctrl !== 3'b010) begin
               errors++;
               $display("FAIL mode_up_state got %b want 010", ctrl);
            end
         end
      end
      checks++;
      if (n != 0) begin
         errors++;
         $display("FAIL mode_up_pulses got %0d want 0", n);
      end
      btn_mode = 1'b0;
      btn_up = 1'b0;
      repeat (12) tick();
   endtask

   task automatic test_reset_mid_repeat;
      int bad = 0;
      btn_up = 1'b1;
      tick();
      for (int e = 1; e <= 27; e++) begin
         tick();
         if (e == 27) begin
            checks++;
            if (inc !== 1'b1) begin
               errors++;
               $display("FAIL rst_pre_repeat got %b want 1", inc);
            end
         end
      end
      rst = 1'b1;
      #1;
      checks++;
      if ({ctrl, inc, dec, blink} !== 6'b0) begin
         errors++;
         $display("FAIL rst_async got %b want 000000",
                  {ctrl, inc, dec, blink});
      end
      repeat (2) tick();
      rst = 1'b0;
      for (int e = 0; e < 40; e++) begin
         tick();
         if ({ctrl, inc, dec, blink} !== 6'b0) bad++;
      end
      checks++;
      if (bad != 0) begin
         errors++;
         $display("FAIL rst_held_up got %0d bad cycles want 0", bad);
      end
      btn_up = 1'b0;
      repeat (10) tick();
   endtask

   initial begin
      rst = 1'b1;
      btn_mode = 1'b0;
      btn_up = 1'b0;
      btn_down = 1'b0;
      test_reset();
      test_run_ignores_up();
      test_mode_walk();
      press_mode();
      press_mode();
      test_repeat();
      test_bounce_down();
      test_both_held();
      test_timeout();
      test_mode_and_up();
      test_reset_mid_repeat();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
